// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS registers, byte FIFO
// and a start/data/stop serializer driving the tx line.
//
// state  | meaning
// IDLE   | line high, waiting for the FIFO to hold a byte
// START  | start bit (line low) for one bit period
// DATA   | eight data bits, LSB first, one bit period each
// STOP   | stop bit (line high); chains straight into START if more is queued
module mmio_uart_tx #(
  parameter logic [8:0] BASE_ADDR    = 9'h140,
  parameter int         CLKS_PER_BIT = 434,
  parameter int         FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  mem_cmd,
  input  logic [8:0]  mem_addr,
  input  logic [15:0] write_data,
  output logic [15:0] read_data,
  output logic        rd_sel,
  output logic        tx,
  output logic        busy
);

  localparam int              PW          = $clog2(FIFO_DEPTH);
  localparam int              CW          = PW + 1;
  localparam int              BW          = $clog2(CLKS_PER_BIT);
  localparam logic [8:0]      STATUS_ADDR = BASE_ADDR + 9'd1;
  localparam logic [CW-1:0]   DEPTH_C     = CW'(FIFO_DEPTH);
  localparam logic [BW-1:0]   BAUD_LAST   = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  // bus decode
  logic is_read, is_write, hit_data, hit_stat;
  logic push_req, push, pop, clr_ovf;

  assign is_read  = (mem_cmd == 2'b01);
  assign is_write = (mem_cmd == 2'b10);
  assign hit_data = (mem_addr == BASE_ADDR);
  assign hit_stat = (mem_addr == STATUS_ADDR);
  assign rd_sel   = is_read && (hit_data || hit_stat);
  assign push_req = is_write && hit_data;
  assign clr_ovf  = is_write && hit_stat && write_data[3];

  // high byte of a TXDATA store carries nothing
  logic unused_hi;
  assign unused_hi = ^write_data[15:8];

  // FIFO storage and bookkeeping
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic          full, empty, ovf;

  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);
  // a pop in the same cycle frees the slot, so a full FIFO still takes the byte
  assign push  = push_req && (!full || pop);

  // serializer registers
  state_t        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    sh_q, sh_d;
  logic          bit_end;

  assign bit_end = (baud_q == BAUD_LAST);

  // FIFO data array; contents need no reset because count gates every read
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= write_data[7:0];
  end

  // FIFO pointers, occupancy and sticky overflow flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (clr_ovf)                ovf <= 1'b0;
      else if (push_req && !push) ovf <= 1'b1;
    end
  end

  // serializer state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
    end
  end

  // serializer next-state, baud timing and FIFO pop
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    pop     = 1'b0;
    if (state_q != S_IDLE) baud_d = bit_end ? '0 : baud_q + BW'(1);
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          sh_d    = mem[rd_ptr];
          baud_d  = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          idx_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          sh_d  = {1'b0, sh_q[7:1]};
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (!empty) begin
            pop     = 1'b1;
            sh_d    = mem[rd_ptr];
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // line level is decoded from state so reset forces it high immediately
  always_comb begin
    tx = 1'b1;
    case (state_q)
      S_START: tx = 1'b0;
      S_DATA:  tx = sh_q[0];
      default: tx = 1'b1;
    endcase
  end

  assign busy = (state_q != S_IDLE) || !empty;

  // register read mux; TXDATA reads back as zero
  always_comb begin
    read_data = 16'h0000;
    if (rd_sel && hit_stat) read_data = {12'b0, ovf, busy, full, empty};
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: a queue/timer reference model predicts accepted
// bytes and STATUS; a line monitor decodes frames and checks them against
// the expected-byte scoreboard.
module tb_mmio_uart_tx;

  localparam int         CPB    = 4;
  localparam int         DEPTH  = 4;
  localparam int         FRAME  = 10 * CPB;
  localparam logic [8:0] A_DATA = 9'h140;
  localparam logic [8:0] A_STAT = 9'h141;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  mem_cmd = 2'b00;
  logic [8:0]  mem_addr = 9'h000;
  logic [15:0] write_data = 16'h0000;
  logic [15:0] read_data;
  logic        rd_sel, tx, busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [7:0] mq[$];
  logic [7:0] exp_q[$];
  int         frame_start[$];
  int         m_rem = 0;
  logic       m_ovf = 1'b0;

  mmio_uart_tx #(
    .BASE_ADDR   (A_DATA),
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .mem_cmd   (mem_cmd),
    .mem_addr  (mem_addr),
    .write_data(write_data),
    .read_data (read_data),
    .rd_sel    (rd_sel),
    .tx        (tx),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: FIFO as a queue, serializer as "cycles left in the current frame".
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mq.delete();
      exp_q.delete();
      m_rem = 0;
      m_ovf = 1'b0;
    end else begin
      if (m_rem > 0) m_rem--;
      if (m_rem == 0 && mq.size() > 0) begin
        void'(mq.pop_front());
        m_rem = FRAME;
      end
      if (mem_cmd == 2'b10 && mem_addr == A_DATA) begin
        if (mq.size() < DEPTH) begin
          mq.push_back(write_data[7:0]);
          exp_q.push_back(write_data[7:0]);
        end else begin
          m_ovf = 1'b1;
        end
      end
      if (mem_cmd == 2'b10 && mem_addr == A_STAT && write_data[3]) m_ovf = 1'b0;
    end
  end

  function automatic logic [15:0] m_status();
    logic b;
    b = (m_rem > 0) || (mq.size() > 0);
    return {12'b0, m_ovf, b, (mq.size() == DEPTH), (mq.size() == 0)};
  endfunction

  // Line monitor: find start bits, sample mid-bit, compare against the scoreboard.
  initial begin : monitor
    logic       prev;
    logic [9:0] bits;
    logic       ok;
    logic [7:0] e;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (reset_n && prev && !tx) begin
        frame_start.push_back(cyc);
        ok   = 1'b1;
        bits = '1;
        for (int k = 1; k < FRAME; k++) begin
          @(negedge clk);
          if (!reset_n) ok = 1'b0;
          if (k % CPB == CPB / 2) bits[k / CPB] = tx;
        end
        if (ok) begin
          check("frame_start_bit", bits[0], 0);
          check("frame_stop_bit", bits[9], 1);
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL frame_unexpected: got byte %0h expected no frame", bits[8:1]);
          end else begin
            e = exp_q.pop_front();
            check("frame_data", bits[8:1], e);
          end
        end
      end
      prev = tx;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [8:0] addr, input logic [15:0] data, output int edge_cyc);
    mem_cmd    = 2'b10;
    mem_addr   = addr;
    write_data = data;
    @(posedge clk);
    #1;
    edge_cyc = cyc;
    mem_cmd  = 2'b00;
  endtask

  task automatic bus_read(input string name, input logic [8:0] addr,
                          input logic exp_sel, input logic [15:0] exp_data);
    mem_cmd  = 2'b01;
    mem_addr = addr;
    @(negedge clk);
    check({name, "_sel"}, rd_sel, exp_sel);
    check({name, "_data"}, read_data, exp_data);
    @(posedge clk);
    #1;
    mem_cmd = 2'b00;
  endtask

  task automatic read_status(input string name, output logic [15:0] v);
    mem_cmd  = 2'b01;
    mem_addr = A_STAT;
    @(negedge clk);
    v = read_data;
    check({name, "_sel"}, rd_sel, 1);
    check(name, read_data, m_status());
    @(posedge clk);
    #1;
    mem_cmd = 2'b00;
  endtask

  task automatic wait_idle(input int budget, output int c);
    c = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) begin
        c = cyc;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin : stim
    int          w, w1, c, n0, r;
    logic [15:0] s;

    // reset held with a TXDATA store on the bus
    reset_n    = 1'b0;
    mem_cmd    = 2'b10;
    mem_addr   = A_DATA;
    write_data = 16'h00AA;
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_rd_sel", rd_sel, 0);
    check("rst_read_data", read_data, 0);
    @(posedge clk);
    #1;
    mem_cmd = 2'b00;
    reset_n = 1'b1;
    tick(1);
    read_status("rst_status", s);
    check("rst_status_val", s, 16'h0001);

    // single byte
    n0 = frame_start.size();
    bus_write(A_DATA, 16'hAB55, w);
    wait_idle(200, c);
    check("sb_tx_fall", (frame_start.size() > n0) ? frame_start[n0] : -1, w + 1);
    check("sb_busy_fall", c, w + 1 + FRAME);

    // back-to-back frames
    n0 = frame_start.size();
    bus_write(A_DATA, 16'h0041, w1);
    bus_write(A_DATA, 16'h0042, w);
    bus_write(A_DATA, 16'h0043, w);
    tick(45);
    read_status("b2b_mid_status", s);
    check("b2b_mid_not_empty", s[0], 0);
    wait_idle(400, c);
    check("b2b_frames", frame_start.size(), n0 + 3);
    if (frame_start.size() >= n0 + 3) begin
      check("b2b_f0", frame_start[n0],     w1 + 1);
      check("b2b_f1", frame_start[n0 + 1], w1 + 1 + FRAME);
      check("b2b_f2", frame_start[n0 + 2], w1 + 1 + 2 * FRAME);
    end
    check("b2b_busy_fall", c, w1 + 1 + 3 * FRAME);
    read_status("b2b_end_status", s);
    check("b2b_end_empty", s[0], 1);

    // overflow: six stores back-to-back from empty
    n0 = frame_start.size();
    bus_write(A_DATA, 16'($urandom), w1);
    for (int i = 1; i < 6; i++) bus_write(A_DATA, 16'($urandom), w);
    read_status("ovf_status", s);
    check("ovf_status_val", s, 16'h000E);
    bus_write(A_STAT, 16'h0008, w);
    read_status("ovf_clr_status", s);
    check("ovf_clr_status_val", s, 16'h0006);
    wait_idle(400, c);
    check("ovf_frames", frame_start.size(), n0 + 5);
    check("ovf_busy_fall", c, w1 + 1 + 5 * FRAME);

    // address decode
    bus_read("dec_142", 9'h142, 1'b0, 16'h0000);
    bus_read("dec_13f", 9'h13F, 1'b0, 16'h0000);
    bus_write(9'h142, 16'h00FF, w);
    tick(2);
    check("dec_nopush_busy", busy, 0);
    mem_cmd  = 2'b11;
    mem_addr = A_DATA;
    @(negedge clk);
    check("dec_cmd11_sel", rd_sel, 0);
    @(posedge clk);
    #1;
    mem_cmd = 2'b00;
    tick(2);
    check("dec_cmd11_busy", busy, 0);
    bus_read("dec_txdata", A_DATA, 1'b1, 16'h0000);

    // reset during data bit 3 with two bytes still queued
    bus_write(A_DATA, 16'h00F0, w1);
    bus_write(A_DATA, 16'h0033, w);
    bus_write(A_DATA, 16'h00CC, w);
    tick(w1 + 18 - cyc);
    check("mid_pre_tx", tx, 0);
    reset_n = 1'b0;
    #1;
    check("mid_rst_tx", tx, 1);
    check("mid_rst_busy", busy, 0);
    tick(3);
    reset_n = 1'b1;
    n0 = frame_start.size();
    tick(100);
    check("mid_after_busy", busy, 0);
    check("mid_after_frames", frame_start.size(), n0);
    read_status("mid_after_status", s);
    check("mid_after_status_val", s, 16'h0001);

    // randomized traffic against the model
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      if (r < 5)       bus_write(A_DATA, 16'($urandom), w);
      else if (r < 7)  read_status("rnd_status", s);
      else if (r == 7) bus_write(A_STAT, 16'($urandom), w);
      else             tick($urandom_range(1, 60));
    end
    wait_idle(3000, c);
    check("rnd_drain_busy", busy, 0);
    read_status("rnd_end_status", s);
    tick(2);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
